id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage RISC-V core, directly downstream of the main decoder. It registers the decoder's control bundle together with the ID-stage operands, immediate, funct bits and register addresses for the EX stage. It also performs load-use hazard detection against its own registered contents, inserts one-cycle bubbles, and counts bubbles and flushes for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters (minimum 2).

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  ID holds a real instruction.
- hold_i  in  1  global freeze (memory stall); all state holds.
- flush_i  in  1  kill the instruction currently in ID (branch taken).
- ALUOp_i  in  2  decoder control.
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i  in  1 each  decoder control.
- rs1_data_i, rs2_data_i, imm_i  in  32 each  ID operands and sign-extended immediate.
- funct_i  in  10  {funct7, funct3}.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register indices.
- stall_o  out  1  combinational; holds PC and IF/ID when 1.
- valid_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o  out  registered copies of the inputs.
- rs1_data_o, rs2_data_o, imm_o (32), funct_o (10), rs1_addr_o, rs2_addr_o, rd_addr_o (5)  out  registered copies of the inputs.
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted.
- flush_cnt_o  out  CNT_W  count of flushes applied.

## Operation
- Hazard term: hazard = valid_i & valid_o & MemRead_o & (rd_addr_o != 0) & ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i)). Both sources are compared regardless of instruction format.
- stall_o = hazard & ~flush_i & ~hold_i.
- Per-edge priority:
  1. rst_i: every output register and counter is cleared to 0.
  2. hold_i: every register and counter keeps its value.
  3. flush_i: load a bubble; flush_cnt increments.
  4. hazard: load a bubble; bubble_cnt increments.
  5. Otherwise: load all inputs; valid_o = valid_i.
- Bubble contents:
  - All control outputs are 0, including valid_o.
  - rd_addr_o = 0.
  - All data, address and funct fields are 0, so the register contents are deterministic.
- When valid_i = 0 and no flush or hazard applies, the inputs are loaded as-is, with valid_o = 0 and controls as presented. Because of the term hazard, these controls have no hazard effect.
- Counters saturate at 2^CNT_W - 1 and never wrap. At most one counter increments per cycle.
- The block has no FSM beyond the register contents. Each load-use stall is exactly one cycle: the bubble clears MemRead_o, which drops hazard on the next cycle.

## Timing
- Input-to-output latency is 1 cycle.
- stall_o is combinational from the registered outputs and the current ID inputs, and is valid in the same cycle.
- Reset values: all outputs 0, including stall_o (valid_o = 0 forces hazard to 0).
- Back-to-back loads:
  - Independent loads pass with no stall.
  - A load followed by a dependent instruction costs exactly 1 bubble.
- hold_i asserted during a hazard:
  - stall_o = 0 for that cycle; the freeze already holds upstream.
  - The hazard is re-evaluated after hold_i drops.
- flush_i and hazard asserted together: the flush wins; flush_cnt increments; bubble_cnt does not.
- rst_i asserted while a bubble is pending: the reset wins, and no stall occurs on the cycle after reset.

## Test plan
- **Reset / pass-through.** Assert rst_i for 2 cycles, then present add x3,x1,x2 (RegWrite=1, ALUOp=2'b10, rs1_data=5, rs2_data=7, valid_i=1). Required response:
  - All outputs are 0 during reset.
  - On the next edge, the outputs equal the inputs and stall_o = 0.
- **Load-use on rs1.** Load lw x5 (MemRead=1, rd=5), then present add x6,x5,x1. Required response:
  - stall_o = 1 for one cycle.
  - The next edge loads a bubble (valid_o=0, RegWrite_o=0) and bubble_cnt_o = 1.
  - On the following edge, the add loads with stall_o = 0.
- **x0 destination.** Load lw x0, then present add x1,x0,x0. Required response: stall_o = 0 and the add loads on the next edge.
- **Flush and hazard together.** Set up the load-use condition on rs2 and assert flush_i in the same cycle. Required response:
  - stall_o = 0 and a bubble is loaded.
  - flush_cnt_o = 1 and bubble_cnt_o = 0.
- **Hold.** With add x3 registered, drive new inputs while hold_i = 1 for 3 cycles. Required response:
  - The outputs and counters are unchanged, and stall_o = 0 even when the hazard condition is true.
  - After release, normal loading resumes.
- **Saturation.** With CNT_W = 4, generate 20 load-use hazards. Required response: bubble_cnt_o stops at 15; one further flush moves flush_cnt_o from 0 to 1.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, bubble insertion and perf counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             ALUSrc_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             Branch_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic [31:0]      imm_i,
    input  logic [9:0]       funct_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             Branch_o,
    output logic [31:0]      rs1_data_o,
    output logic [31:0]      rs2_data_o,
    output logic [31:0]      imm_o,
    output logic [9:0]       funct_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int BW = 1 + 2 + 6 + 96 + 10 + 15;
    logic [BW-1:0] inBus, pipeReg;
    logic hazard;
    assign inBus = {valid_i, ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i,
                    rs1_data_i, rs2_data_i, imm_i, funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i};
    assign {valid_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o,
            rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o} = pipeReg;
    assign hazard = valid_i & valid_o & MemRead_o & (rd_addr_o != 5'd0) &
                    ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i));
    assign stall_o = hazard & ~flush_i & ~hold_i;
    // A bubble is the all-zero bundle; flush outranks hazard so only one counter moves per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipeReg      <= '0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else if (!hold_i) begin
            pipeReg <= (flush_i | hazard) ? '0 : inBus;
            if (flush_i)
                flush_cnt_o <= flush_cnt_o + CNT_W'(flush_cnt_o != '1);
            else if (hazard)
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(bubble_cnt_o != '1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of pass-through, load-use bubbles, flush, hold, reset and counter saturation.
module tb_id_ex_stage;
    logic clk = 0, rst = 1, valid_i = 0, hold_i = 0, flush_i = 0;
    logic [1:0] ALUOp_i = 0;
    logic ALUSrc_i = 0, RegWrite_i = 0, MemtoReg_i = 0, MemRead_i = 0, MemWrite_i = 0, Branch_i = 0;
    logic [31:0] rs1_data_i = 0, rs2_data_i = 0, imm_i = 0;
    logic [9:0] funct_i = 0;
    logic [4:0] rs1_addr_i = 0, rs2_addr_i = 0, rd_addr_i = 0;
    logic stall_o, valid_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o;
    logic [1:0] ALUOp_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o;
    logic [9:0] funct_o;
    logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [3:0] bubble_cnt_o, flush_cnt_o;
    int total = 0, bad = 0;

    id_ex_stage #(.CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .hold_i(hold_i), .flush_i(flush_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Branch_i(Branch_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .funct_i(funct_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .stall_o(stall_o), .valid_o(valid_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .Branch_o(Branch_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .imm_o(imm_o), .funct_o(funct_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .bubble_cnt_o(bubble_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic v, input logic mr, input logic rw, input logic [1:0] op,
                            input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [31:0] d1, input logic [31:0] d2);
        valid_i = v; MemRead_i = mr; MemtoReg_i = mr; ALUSrc_i = mr; RegWrite_i = rw; ALUOp_i = op;
        rd_addr_i = rd; rs1_addr_i = r1; rs2_addr_i = r2; rs1_data_i = d1; rs2_data_i = d2;
        imm_i = mr ? 32'd8 : 32'd0; funct_i = mr ? 10'h002 : 10'h000;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        setInstr(1, 1, 1, 2'b11, 5'd9, 5'd9, 5'd9, 32'hdead, 32'hbeef);
        step();
        step();
        total++; if (valid_o !== 0 || MemRead_o !== 0 || RegWrite_o !== 0 || ALUOp_o !== 0) begin bad++; $display("FAIL reset_ctrl got v=%b mr=%b rw=%b op=%b want 0", valid_o, MemRead_o, RegWrite_o, ALUOp_o); end
        total++; if (rs1_data_o !== 0 || rs2_data_o !== 0 || imm_o !== 0 || funct_o !== 0 || rd_addr_o !== 0 || rs1_addr_o !== 0) begin bad++; $display("FAIL reset_data got d1=%h d2=%h imm=%h rd=%0d want 0", rs1_data_o, rs2_data_o, imm_o, rd_addr_o); end
        total++; if (stall_o !== 0 || bubble_cnt_o !== 0 || flush_cnt_o !== 0) begin bad++; $display("FAIL reset_misc got stall=%b bc=%0d fc=%0d want 0", stall_o, bubble_cnt_o, flush_cnt_o); end
        rst = 0;
    endtask

    task automatic test_passthrough();
        setInstr(1, 0, 1, 2'b10, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        total++; if (stall_o !== 0) begin bad++; $display("FAIL pass_stall got %b want 0", stall_o); end
        step();
        total++; if (valid_o !== 1 || RegWrite_o !== 1 || ALUOp_o !== 2'b10 || MemRead_o !== 0) begin bad++; $display("FAIL pass_ctrl got v=%b rw=%b op=%b mr=%b want 1 1 10 0", valid_o, RegWrite_o, ALUOp_o, MemRead_o); end
        total++; if (rs1_data_o !== 5 || rs2_data_o !== 7 || rd_addr_o !== 3 || rs1_addr_o !== 1 || rs2_addr_o !== 2) begin bad++; $display("FAIL pass_data got d1=%0d d2=%0d rd=%0d r1=%0d r2=%0d want 5 7 3 1 2", rs1_data_o, rs2_data_o, rd_addr_o, rs1_addr_o, rs2_addr_o); end
        total++; if (stall_o !== 0) begin bad++; $display("FAIL pass_stall2 got %b want 0", stall_o); end
    endtask

    task automatic test_load_use();
        setInstr(1, 1, 1, 2'b00, 5'd5, 5'd2, 5'd0, 32'd100, 32'd0);
        step();
        total++; if (MemRead_o !== 1 || imm_o !== 8 || funct_o !== 10'h002 || ALUSrc_o !== 1 || MemtoReg_o !== 1) begin bad++; $display("FAIL lu_load got mr=%b imm=%0d f=%h want 1 8 002", MemRead_o, imm_o, funct_o); end
        setInstr(1, 0, 1, 2'b10, 5'd6, 5'd5, 5'd1, 32'd11, 32'd22);
        total++; if (stall_o !== 1) begin bad++; $display("FAIL lu_stall got %b want 1", stall_o); end
        step();
        total++; if (valid_o !== 0 || RegWrite_o !== 0 || MemRead_o !== 0 || rd_addr_o !== 0 || rs1_data_o !== 0 || imm_o !== 0) begin bad++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b rd=%0d d1=%0d want zeros", valid_o, RegWrite_o, MemRead_o, rd_addr_o, rs1_data_o); end
        total++; if (bubble_cnt_o !== 1 || flush_cnt_o !== 0) begin bad++; $display("FAIL lu_bcnt got bc=%0d fc=%0d want 1 0", bubble_cnt_o, flush_cnt_o); end
        total++; if (stall_o !== 0) begin bad++; $display("FAIL lu_stall_clear got %b want 0", stall_o); end
        step();
        total++; if (valid_o !== 1 || rd_addr_o !== 6 || rs1_addr_o !== 5 || rs1_data_o !== 11 || bubble_cnt_o !== 1) begin bad++; $display("FAIL lu_resume got v=%b rd=%0d r1=%0d d1=%0d bc=%0d want 1 6 5 11 1", valid_o, rd_addr_o, rs1_addr_o, rs1_data_o, bubble_cnt_o); end
    endtask

    task automatic test_x0();
        setInstr(1, 1, 1, 2'b00, 5'd0, 5'd2, 5'd0, 32'd0, 32'd0);
        step();
        setInstr(1, 0, 1, 2'b10, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0);
        total++; if (stall_o !== 0) begin bad++; $display("FAIL x0_stall got %b want 0", stall_o); end
        step();
        total++; if (valid_o !== 1 || rd_addr_o !== 1 || bubble_cnt_o !== 1) begin bad++; $display("FAIL x0_load got v=%b rd=%0d bc=%0d want 1 1 1", valid_o, rd_addr_o, bubble_cnt_o); end
    endtask

    task automatic test_reset_pending();
        setInstr(1, 1, 1, 2'b00, 5'd5, 5'd2, 5'd0, 32'd0, 32'd0);
        step();
        setInstr(1, 0, 1, 2'b10, 5'd6, 5'd5, 5'd1, 32'd0, 32'd0);
        total++; if (stall_o !== 1) begin bad++; $display("FAIL rp_stall got %b want 1", stall_o); end
        rst = 1;
        step();
        rst = 0;
        #1;
        total++; if (valid_o !== 0 || MemRead_o !== 0 || stall_o !== 0 || bubble_cnt_o !== 0 || flush_cnt_o !== 0) begin bad++; $display("FAIL rp_reset got v=%b mr=%b stall=%b bc=%0d fc=%0d want 0", valid_o, MemRead_o, stall_o, bubble_cnt_o, flush_cnt_o); end
    endtask

    task automatic test_flush_hazard();
        setInstr(1, 1, 1, 2'b00, 5'd7, 5'd2, 5'd0, 32'd0, 32'd0);
        step();
        setInstr(1, 0, 1, 2'b10, 5'd8, 5'd1, 5'd7, 32'd3, 32'd4);
        flush_i = 1;
        #1;
        total++; if (stall_o !== 0) begin bad++; $display("FAIL fh_stall got %b want 0", stall_o); end
        step();
        flush_i = 0;
        total++; if (valid_o !== 0 || rd_addr_o !== 0 || RegWrite_o !== 0 || rs2_data_o !== 0) begin bad++; $display("FAIL fh_bubble got v=%b rd=%0d rw=%b d2=%0d want zeros", valid_o, rd_addr_o, RegWrite_o, rs2_data_o); end
        total++; if (flush_cnt_o !== 1 || bubble_cnt_o !== 0) begin bad++; $display("FAIL fh_cnt got fc=%0d bc=%0d want 1 0", flush_cnt_o, bubble_cnt_o); end
    endtask

    task automatic test_hold();
        setInstr(1, 0, 1, 2'b10, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        step();
        hold_i = 1;
        setInstr(1, 1, 1, 2'b00, 5'd5, 5'd4, 5'd0, 32'd9, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (valid_o !== 1 || rd_addr_o !== 3 || rs1_data_o !== 5 || MemRead_o !== 0 || flush_cnt_o !== 1 || bubble_cnt_o !== 0) begin bad++; $display("FAIL hold_keep[%0d] got v=%b rd=%0d d1=%0d mr=%b fc=%0d bc=%0d want 1 3 5 0 1 0", i, valid_o, rd_addr_o, rs1_data_o, MemRead_o, flush_cnt_o, bubble_cnt_o); end
        end
        hold_i = 0;
        step();
        total++; if (MemRead_o !== 1 || rd_addr_o !== 5 || rs1_data_o !== 9) begin bad++; $display("FAIL hold_release got mr=%b rd=%0d d1=%0d want 1 5 9", MemRead_o, rd_addr_o, rs1_data_o); end
        hold_i = 1;
        setInstr(1, 0, 1, 2'b10, 5'd6, 5'd5, 5'd1, 32'd0, 32'd0);
        total++; if (stall_o !== 0) begin bad++; $display("FAIL hold_stall got %b want 0", stall_o); end
        step();
        total++; if (MemRead_o !== 1 || rd_addr_o !== 5 || bubble_cnt_o !== 0) begin bad++; $display("FAIL hold_haz_keep got mr=%b rd=%0d bc=%0d want 1 5 0", MemRead_o, rd_addr_o, bubble_cnt_o); end
        hold_i = 0;
        #1;
        total++; if (stall_o !== 1) begin bad++; $display("FAIL hold_reeval got %b want 1", stall_o); end
        step();
        total++; if (valid_o !== 0 || bubble_cnt_o !== 1 || flush_cnt_o !== 1) begin bad++; $display("FAIL hold_bubble got v=%b bc=%0d fc=%0d want 0 1 1", valid_o, bubble_cnt_o, flush_cnt_o); end
    endtask

    task automatic test_saturation();
        int expB = 0;
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            setInstr(1, 1, 1, 2'b00, 5'd5, 5'd2, 5'd0, 32'd0, 32'd0);
            step();
            setInstr(1, 0, 1, 2'b10, 5'd6, 5'd1, 5'd5, 32'd0, 32'd0);
            step();
            expB = (expB < 15) ? expB + 1 : 15;
            total++; if (bubble_cnt_o !== 4'(expB)) begin bad++; $display("FAIL sat_bcnt[%0d] got %0d want %0d", i, bubble_cnt_o, expB); end
        end
        flush_i = 1;
        step();
        flush_i = 0;
        total++; if (flush_cnt_o !== 1 || bubble_cnt_o !== 15) begin bad++; $display("FAIL sat_flush got fc=%0d bc=%0d want 1 15", flush_cnt_o, bubble_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0();
        test_reset_pending();
        test_flush_hazard();
        test_hold();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
